iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Parametrised multi-cycle integer divider for the execute stage; successor to the fixed 64-bit divider.
- Generalised in operand width (XLEN) and throughput (bits retired per cycle).
- Adds functionality the old unit lacked:
  - full RISC-V DIV/DIVU/REM/REMU and W-variant semantics resolved internally (sign handling, divide-by-zero, signed overflow);
  - valid/ready handshake on both sides;
  - flush.
- Execute stage drives raw rs1/rs2 operands and takes the final XLEN result; no pre/post sign fix-up logic remains in execute.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
BPC, 1, quotient bits retired per CALC cycle; legal values 1, 2, 4.
WORD_EN, 1, enables op_word; must be 0 when XLEN=32.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted at 0).
flush  in  1  abort current operation (pipeline redirect).
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request.
a  in  XLEN  dividend (raw rs1).
b  in  XLEN  divisor (raw rs2).
op_signed  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU.
op_word  in  1  1 = *W variant: operate on [31:0], sign-extend result.
op_rem  in  1  1 = return remainder, 0 = return quotient.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
result  out  XLEN  quotient or remainder.
busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset (reset=0, async) -> IDLE, iteration counter 0, result 0, out_valid 0.
- in_ready = (state==IDLE) && !flush. Accept = in_valid && in_ready; a, b and op bits are latched on that edge.
- Effective width W:
  - op_word: W=32. Signed: a, b taken as sign-extended [31:0]. Unsigned: zero-extended [31:0].
  - otherwise: W=XLEN.
- Magnitudes are taken at accept: |a|, |b| if signed, else raw. Quotient sign = sa^sb. Remainder sign = sa.
- Special cases are detected at accept, skip CALC/FIX and go IDLE->DONE:
  - b==0: quotient = all ones; remainder = a (word: sext(a[31:0])).
  - Signed overflow (a = most-negative W-bit value, b = -1): quotient = a (word: sext); remainder = 0.
- Special-case results appear with out_valid high in the cycle after the accept edge.
- Normal path: IDLE->CALC. CALC runs a restoring shift-subtract, BPC bits per cycle, for exactly W/BPC cycles, counted by the iteration counter.
- CALC->FIX: FIX (1 cycle) negates quotient/remainder per the recorded signs, selects by op_rem, and sign-extends from bit 31 when op_word. This applies to unsigned W variants too.
- FIX->DONE. out_valid = (state==DONE). result is registered and stable while in DONE.
- Latency: out_valid first high W/BPC + 2 cycles after the accept edge. For XLEN=64, BPC=1: 66 (64-bit), 34 (word).
- DONE: when out_ready=1, go to IDLE on that edge. When out_ready=0, hold result and out_valid indefinitely.
- No new request is accepted in the same cycle the result is consumed; in_ready rises one cycle later. Throughput is one op per W/BPC + 3 cycles minimum.
- flush=1 in any state: next edge -> IDLE, out_valid 0, in_ready 0 during the flush cycle. A flush coinciding with out_valid && out_ready still discards the result; the consumer must qualify with its own flush.
- Changes on a/b/op inputs after accept have no effect.
- op_word with WORD_EN=0 is treated as op_word=0.
- Results are never X. Inputs are ignored while busy.

Test Plan:
1. XLEN=64, BPC=1: a=100, b=7, unsigned, quotient; out_ready=1 -> result=14, out_valid first high exactly 66 cycles after accept, in_ready high the cycle after consumption. Repeat with op_rem -> 2.
2. Signed: a=-7, b=2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD), remainder -1. a=7, b=-2 -> quotient -3, remainder 1.
3. Special cases:
   - b=0, a=0x1234 -> quotient all ones, remainder 0x1234, each in 1 cycle.
   - a=0x8000_0000_0000_0000, b=-1, signed -> quotient 0x8000_0000_0000_0000, remainder 0.
4. Word mode:
   - DIVW a=0xFFFF_FFFF_8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000.
   - DIVUW a=0x1_FFFF_FFFE, b=1 -> 0xFFFF_FFFF_FFFF_FFFE; latency 34 cycles.
5. Backpressure and flush:
   - Hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready 0.
   - Assert flush at CALC cycle 20 -> IDLE next edge, no out_valid. A new op (a=9, b=3) then completes with 3.
6. Reset mid-CALC (reset=0 asynchronously) -> outputs 0 immediately, IDLE. Rerun directed cases with BPC=2 and BPC=4 -> same results, latencies 34 and 18 (64-bit).

Source files
------------

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring integer divider for the execute stage.
// Takes raw rs1/rs2 operands and resolves RISC-V DIV/DIVU/REM/REMU and the
// *W variants internally: sign handling, divide-by-zero and signed overflow.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   flush           abort any operation, return to idle on the next edge
//   in_valid/ready  request handshake; a, b, op_* are latched on accept
//   out_valid/ready result handshake; result is held stable while in DONE
//   result          quotient or remainder, XLEN bits
//   busy            unit is not idle
module iter_divider #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned BPC     = 1,
    parameter bit          WORD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            op_signed,
    input  logic            op_word,
    input  logic            op_rem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CntW = $clog2(XLEN / BPC + 1);
    localparam logic [CntW-1:0] ItersFull = CntW'(XLEN / BPC);
    localparam logic [CntW-1:0] ItersWord = CntW'(32 / BPC);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;      // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;      // divisor magnitude
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              rem_sel_q, rem_sel_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // Operand conditioning at accept time.
    logic            word_in, accept, sa, sb, div_zero, ovf;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_aligned, min_neg;

    always_comb begin
        word_in = WORD_EN && op_word;
        if (word_in) begin
            a_ext   = op_signed ? sext32(a[31:0]) : zext32(a[31:0]);
            b_ext   = op_signed ? sext32(b[31:0]) : zext32(b[31:0]);
            min_neg = sext32(32'h8000_0000);
        end else begin
            a_ext   = a;
            b_ext   = b;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        sa       = op_signed & a_ext[XLEN-1];
        sb       = op_signed & b_ext[XLEN-1];
        a_mag    = sa ? -a_ext : a_ext;
        b_mag    = sb ? -b_ext : b_ext;
        // Word dividends sit in the top 32 bits so the MSB-first loop works unchanged.
        a_aligned = word_in ? (a_mag << (XLEN - 32)) : a_mag;
        div_zero = (b_ext == '0);
        ovf      = op_signed && (a_ext == min_neg) && (b_ext == '1);
    end

    assign in_ready = (state_q == StIdle) && !flush;
    assign accept   = in_valid && in_ready;

    // BPC restoring shift-subtract steps per cycle.
    logic [XLEN-1:0] quo_step, rem_step;
    logic [XLEN:0]   trial;

    always_comb begin
        quo_step = quo_q;
        rem_step = rem_q;
        trial    = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            trial    = {rem_step, quo_step[XLEN-1]};
            quo_step = {quo_step[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial       = trial - {1'b0, dvs_q};
                quo_step[0] = 1'b1;
            end
            rem_step = trial[XLEN-1:0];
        end
    end

    // Sign fix-up and selection.
    logic [XLEN-1:0] q_fix, r_fix, res_fix;

    always_comb begin
        q_fix   = q_neg_q ? -quo_q : quo_q;
        r_fix   = r_neg_q ? -rem_q : rem_q;
        res_fix = rem_sel_q ? r_fix : q_fix;
        if (word_q) begin
            res_fix = sext32(res_fix[31:0]);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        rem_sel_d = rem_sel_q;
        word_d    = word_q;
        result_d  = result_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    word_d    = word_in;
                    rem_sel_d = op_rem;
                    q_neg_d   = sa ^ sb;
                    r_neg_d   = sa;
                    if (div_zero) begin
                        result_d = op_rem ? (word_in ? sext32(a[31:0]) : a) : '1;
                        state_d  = StDone;
                    end else if (ovf) begin
                        result_d = op_rem ? '0 : a_ext;
                        state_d  = StDone;
                    end else begin
                        quo_d   = a_aligned;
                        rem_d   = '0;
                        dvs_d   = b_mag;
                        cnt_d   = word_in ? ItersWord : ItersFull;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = res_fix;
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            word_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            rem_sel_q <= rem_sel_d;
            word_q    <= word_d;
            result_q  <= result_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: three instances (BPC = 1, 2, 4) sharing operands,
// checked against an arithmetic reference of the RISC-V division rules.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] a, b;
    logic        op_signed, op_word, op_rem;
    logic [63:0] res [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        iter_divider #(
            .XLEN   (64),
            .BPC    (1 << g),
            .WORD_EN(1'b1)
        ) u_dut (
            .clk      (clk),
            .reset    (rst_n),
            .flush    (flush[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a),
            .b        (b),
            .op_signed(op_signed),
            .op_word  (op_word),
            .op_rem   (op_rem),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .result   (res[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics expressed with plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [63:0] ra, input logic [63:0] rb,
                                              input bit s, input bit w, input bit r);
        logic [31:0]        a32, b32, r32;
        logic signed [31:0] sa32, sb32;
        logic [63:0]        r64;
        logic signed [63:0] sa64, sb64;
        if (w) begin
            a32 = ra[31:0];
            b32 = rb[31:0];
            sa32 = a32;
            sb32 = b32;
            if (b32 == 32'd0) r32 = r ? a32 : 32'hFFFF_FFFF;
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = r ? 32'd0 : a32;
            else if (s && r) r32 = sa32 % sb32;
            else if (s) r32 = sa32 / sb32;
            else if (r) r32 = a32 % b32;
            else r32 = a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        sa64 = ra;
        sb64 = rb;
        if (rb == 64'd0) r64 = r ? ra : '1;
        else if (s && ra == 64'h8000_0000_0000_0000 && rb == '1) r64 = r ? 64'd0 : ra;
        else if (s && r) r64 = sa64 % sb64;
        else if (s) r64 = sa64 / sb64;
        else if (r) r64 = ra % rb;
        else r64 = ra / rb;
        return r64;
    endfunction

    function automatic int exp_latency(input int d, input logic [63:0] ra, input logic [63:0] rb,
                                       input bit s, input bit w);
        bit special;
        if (w) special = (rb[31:0] == 32'd0) ||
                         (s && ra[31:0] == 32'h8000_0000 && rb[31:0] == 32'hFFFF_FFFF);
        else   special = (rb == 64'd0) || (s && ra == 64'h8000_0000_0000_0000 && rb == '1);
        if (special) return 1;
        return (w ? 32 : 64) / (1 << d) + 2;
    endfunction

    // One transaction on instance d; hold keeps out_ready low for that many DONE cycles.
    task automatic do_op(input int d, input logic [63:0] ta, input logic [63:0] tb_,
                         input bit s, input bit w, input bit r, input int hold);
        logic [63:0] exp;
        int          lat, exp_lat;
        bit          seen;
        exp     = ref_model(ta, tb_, s, w, r);
        exp_lat = exp_latency(d, ta, tb_, s, w);
        for (int i = 0; i < 20 && !in_ready[d]; i++) @(posedge clk) #1;
        check("in_ready_before", {63'd0, in_ready[d]}, 64'd1);
        out_ready[d] = (hold == 0);
        a = ta; b = tb_; op_signed = s; op_word = w; op_rem = r;
        in_valid[d] = 1'b1;
        @(posedge clk) #1;
        in_valid[d] = 1'b0;
        // Post-accept operand changes must not matter.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        op_signed = 1'($urandom); op_word = 1'($urandom); op_rem = 1'($urandom);
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            if (out_valid[d]) begin
                seen = 1;
                lat  = i;
            end else begin
                @(posedge clk) #1;
            end
        end
        check("out_valid_seen", {63'd0, seen}, 64'd1);
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", res[d], exp);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk) #1;
            check("hold_valid", {63'd0, out_valid[d]}, 64'd1);
            check("hold_result", res[d], exp);
            check("hold_in_ready", {63'd0, in_ready[d]}, 64'd0);
        end
        out_ready[d] = 1'b1;
        @(posedge clk) #1;
        check("in_ready_after", {63'd0, in_ready[d]}, 64'd1);
        check("valid_dropped", {63'd0, out_valid[d]}, 64'd0);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 50));
            2: return -64'($urandom_range(1, 50));
            3: return 64'd0;
            4: return '1;
            default: return {$urandom, 32'h8000_0000};
        endcase
    endfunction

    initial begin
        bit          flag;
        logic [63:0] ra, rb;
        rst_n = 1'b0;
        flush = '0; in_valid = '0; out_ready = '1;
        a = '0; b = '0; op_signed = 0; op_word = 0; op_rem = 0;
        #23;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", {63'd0, out_valid[d]}, 64'd0);
            check("rst_result", res[d], 64'd0);
            check("rst_busy", {63'd0, busy[d]}, 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk) #1;

        for (int d = 0; d < 3; d++) begin
            do_op(d, 64'd100, 64'd7, 0, 0, 0, 0);
            do_op(d, 64'd100, 64'd7, 0, 0, 1, 0);
            do_op(d, -64'd7, 64'd2, 1, 0, 0, 0);
            do_op(d, -64'd7, 64'd2, 1, 0, 1, 0);
            do_op(d, 64'd7, -64'd2, 1, 0, 0, 0);
            do_op(d, 64'd7, -64'd2, 1, 0, 1, 0);
            do_op(d, 64'h1234, 64'd0, 0, 0, 0, 0);
            do_op(d, 64'h1234, 64'd0, 1, 0, 1, 0);
            do_op(d, 64'h8000_0000_0000_0000, '1, 1, 0, 0, 0);
            do_op(d, 64'h8000_0000_0000_0000, '1, 1, 0, 1, 0);
            do_op(d, 64'hFFFF_FFFF_8000_0000, '1, 1, 1, 0, 0);
            do_op(d, 64'h1_FFFF_FFFE, 64'd1, 0, 1, 0, 0);
            do_op(d, 64'h1_FFFF_FFF9, 64'd4, 0, 1, 1, 0);
        end

        // Backpressure in DONE.
        do_op(0, 64'd1000, 64'd33, 0, 0, 0, 10);

        // Flush in idle blocks accept.
        flush[0] = 1'b1; in_valid[0] = 1'b1;
        #1 check("flush_idle_in_ready", {63'd0, in_ready[0]}, 64'd0);
        @(posedge clk) #1;
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        check("flush_idle_busy", {63'd0, busy[0]}, 64'd0);

        // Flush at CALC cycle 20.
        a = 64'hDEAD_BEEF_0000_1234; b = 64'd5; op_signed = 0; op_word = 0; op_rem = 0;
        in_valid[0] = 1'b1;
        @(posedge clk) #1;
        in_valid[0] = 1'b0;
        repeat (19) @(posedge clk) #1;
        flush[0] = 1'b1;
        #1 check("flush_in_ready", {63'd0, in_ready[0]}, 64'd0);
        @(posedge clk) #1;
        flush[0] = 1'b0;
        check("flush_busy", {63'd0, busy[0]}, 64'd0);
        flag = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid[0]) flag = 1;
            @(posedge clk) #1;
        end
        check("flush_no_valid", {63'd0, flag}, 64'd0);
        do_op(0, 64'd9, 64'd3, 0, 0, 0, 0);

        // Asynchronous reset mid-CALC.
        a = 64'd12345; b = 64'd7; op_signed = 0; op_word = 0; op_rem = 0;
        in_valid[0] = 1'b1;
        @(posedge clk) #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk) #1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {63'd0, busy[0]}, 64'd0);
        check("async_rst_valid", {63'd0, out_valid[0]}, 64'd0);
        check("async_rst_result", res[0], 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk) #1;

        for (int n = 0; n < 90; n++) begin
            ra = rand_operand();
            rb = rand_operand();
            do_op(n % 3, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
